// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared types and helpers for the sprite memory responder.
//   pixel_t             : 12-bit RGB444 pixel, {R[3:0], G[3:0], B[3:0]}
//   state_t             : responder engine state (IDLE, CLEAR, LOAD)
//   TRANSPARENT_DEFAULT : pixel returned for misses and written by a clear
//   pix_r/pix_g/pix_b   : colour channel extraction
//   make_pixel          : pack three channels into a pixel
package sprite_pkg;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam pixel_t TRANSPARENT_DEFAULT = 12'h000;

  function automatic logic [3:0] pix_r(input pixel_t p);
    return p[11:8];
  endfunction

  function automatic logic [3:0] pix_g(input pixel_t p);
    return p[7:4];
  endfunction

  function automatic logic [3:0] pix_b(input pixel_t p);
    return p[3:0];
  endfunction

  function automatic pixel_t make_pixel(input logic [3:0] r,
                                        input logic [3:0] g,
                                        input logic [3:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/sprite_ram.sv
// sprite_ram
//   Single-port synchronous RAM, DEPTH x 12, no reset on the array.
//   A write and a read share the one address; a read in the same cycle as a
//   write to that address returns the old contents.
//   Ports:
//     clk   : clock
//     we    : write enable
//     addr  : word address (IW bits)
//     wdata : pixel to write
//     q     : registered read data, valid one cycle after addr
module sprite_ram
  import sprite_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        q
);

  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/sprite_mem_responder.sv
// sprite_mem_responder
//   Memory-side responder for the sprite drawer ROM interface. Returns a
//   stored RGB444 pixel exactly two cycles after a read request, and owns a
//   writable store that an internal engine clears (after reset or on demand)
//   and that a streaming load port fills from address 0.
//   Ports:
//     clk, resetN  : clock, asynchronous active-low reset
//     sprite_rd    : read request (valid in the request cycle)
//     sprite_addr  : pixel address, full screen-sized width
//     sprite_data  : returned pixel, registered, valid in cycle N+2
//     clear_start  : one-cycle request to clear the store
//     load_start   : one-cycle request to begin a load at address 0
//     load_valid   : load_data is valid
//     load_data    : pixel to write
//     load_last    : marks the final word of a load
//     load_ready   : store accepts a load word this cycle
//     busy         : engine is clearing or loading
//     done         : one-cycle pulse when a clear or load finishes
//     load_count   : words written by the most recent load
module sprite_mem_responder
  import sprite_pkg::*;
#(
  parameter int     WIDTH       = 640,
  parameter int     HEIGHT      = 480,
  parameter int     DEPTH       = 4096,
  parameter pixel_t TRANSPARENT = TRANSPARENT_DEFAULT,
  localparam int    AW          = $clog2(WIDTH * HEIGHT),
  localparam int    IW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          sprite_rd,
  input  logic [AW-1:0] sprite_addr,
  output pixel_t        sprite_data,
  input  logic          clear_start,
  input  logic          load_start,
  input  logic          load_valid,
  input  pixel_t        load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          busy,
  output logic          done,
  output logic [IW:0]   load_count
);

  state_t        state;
  logic [IW-1:0] ptr;
  logic          last_word;
  logic          hit;
  logic          hit_d;
  logic          ram_we;
  logic [IW-1:0] ram_addr;
  pixel_t        ram_wdata;
  pixel_t        ram_q;

  assign last_word = (ptr == IW'(DEPTH - 1));

  // The range check uses every address bit so addresses past the store
  // never alias onto low words.
  assign hit = sprite_rd && (sprite_addr < AW'(DEPTH)) && (state == IDLE);

  // The engine owns the RAM port whenever it is clearing or loading; reads
  // in those cycles are forced transparent by hit, so their data is unused.
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = TRANSPARENT;
    ram_addr  = sprite_addr[IW-1:0];
    unique case (state)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = ptr;
      end
      LOAD: begin
        ram_we    = load_valid && load_ready;
        ram_wdata = load_data;
        ram_addr  = ptr;
      end
      default: ;
    endcase
  end

  sprite_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Second read stage: the RAM registers the data in stage 1, hit_d travels
  // alongside it and picks data or transparent here.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_d       <= 1'b0;
      sprite_data <= TRANSPARENT;
    end else begin
      hit_d       <= hit;
      sprite_data <= hit_d ? ram_q : TRANSPARENT;
    end
  end

  // Clear/load engine. Reset lands in CLEAR so the store is always wiped
  // from word 0 after any reset, including one that aborts a load.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= CLEAR;
      ptr        <= '0;
      busy       <= 1'b1;
      load_ready <= 1'b0;
      done       <= 1'b0;
      load_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_start) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end else if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_count <= '0;
            busy       <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (last_word) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr        <= ptr + 1'b1;
            load_count <= load_count + 1'b1;
            if (load_last || last_word) begin
              state      <= IDLE;
              busy       <= 1'b0;
              load_ready <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mem_responder.sv
// tb_sprite_mem_responder
//   Self-checking bench for sprite_mem_responder with a 16-word store.
//   Read expectations are queued when a request is driven and compared when
//   the pixel is due two cycles later; control outputs are checked directly.
module tb_sprite_mem_responder;
  import sprite_pkg::*;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(WIDTH * HEIGHT);
  localparam int IW     = $clog2(DEPTH);

  logic          clk;
  logic          resetN;
  logic          sprite_rd;
  logic [AW-1:0] sprite_addr;
  pixel_t        sprite_data;
  logic          clear_start;
  logic          load_start;
  logic          load_valid;
  pixel_t        load_data;
  logic          load_last;
  logic          load_ready;
  logic          busy;
  logic          done;
  logic [IW:0]   load_count;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    pixel_t        exp_pix;
  } read_vec_t;

  typedef struct {
    pixel_t        exp_pix;
    int            due;
    logic [AW-1:0] addr;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t chk_entry;
  pixel_t    model_mem [DEPTH];
  read_vec_t vecs [20];
  int        vec_count;
  int        miss_count;
  int        cyc;

  sprite_mem_responder #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .DEPTH       (DEPTH),
    .TRANSPARENT (12'h000)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .sprite_rd   (sprite_rd),
    .sprite_addr (sprite_addr),
    .sprite_data (sprite_data),
    .clear_start (clear_start),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .busy        (busy),
    .done        (done),
    .load_count  (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pops every read result that is due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      chk_entry = sb.pop_front();
      checkOutput($sformatf("read_addr_%0d", chk_entry.addr),
                  32'(sprite_data), 32'(chk_entry.exp_pix));
    end
  end

  // Drives one full cycle of inputs (starting just after a falling edge)
  // and queues the expected pixel for a checked read.
  task automatic applyStimulus(input logic cs, input logic ls,
                               input logic lv, input pixel_t ld,
                               input logic ll, input logic rd,
                               input logic [AW-1:0] ra, input logic chk,
                               input pixel_t exp_pix);
    clear_start = cs;
    load_start  = ls;
    load_valid  = lv;
    load_data   = ld;
    load_last   = ll;
    sprite_rd   = rd;
    sprite_addr = ra;
    if (chk) sb.push_back('{exp_pix: exp_pix, due: cyc + 2, addr: ra});
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, '0, 1'b0, 12'h000);
  endtask

  task automatic read_cycle(input logic rd, input logic [AW-1:0] ra,
                            input pixel_t exp_pix);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, rd, ra, 1'b1, exp_pix);
  endtask

  task automatic drain();
    sprite_rd = 1'b0;
    for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL drain: %0d reads still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Expects a full-store clear starting at the next rising edge.
  task automatic check_clear_sequence(input string tag);
    for (int k = 1; k <= 17; k++) begin
      idle_cycle();
      checkOutput($sformatf("%s_busy_%0d", tag, k), 32'(busy), 32'(k < 16));
      checkOutput($sformatf("%s_done_%0d", tag, k), 32'(done), 32'(k == 16));
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 12'h000;
  endtask

  // Loads DEPTH words base+i with no load_last; exit is on the last word.
  task automatic full_load(input pixel_t base, input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, '0, 1'b0, 12'h000);
    checkOutput({tag, "_ready_start"}, 32'(load_ready), 32'd1);
    checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, pixel_t'(base + 12'(i)), 1'b0,
                    1'b0, '0, 1'b0, 12'h000);
      model_mem[i] = pixel_t'(base + 12'(i));
      if (i < DEPTH - 1) begin
        checkOutput($sformatf("%s_ready_%0d", tag, i), 32'(load_ready), 32'd1);
        checkOutput($sformatf("%s_done_%0d", tag, i), 32'(done), 32'd0);
      end
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready_end"}, 32'(load_ready), 32'd0);
    checkOutput({tag, "_count"}, 32'(load_count), 32'(DEPTH));
    idle_cycle();
    checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_done;
    int n_busy;
    int n_ready;

    vec_count   = 0;
    miss_count  = 0;
    cyc         = 0;
    resetN      = 1'b0;
    sprite_rd   = 1'b0;
    sprite_addr = '0;
    clear_start = 1'b0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_data   = 12'h000;
    load_last   = 1'b0;

    for (int i = 0; i < DEPTH; i++) vecs[i] = '{1'b1, AW'(i), pixel_t'(12'h100 + 12'(i))};
    vecs[16] = '{1'b1, AW'(16), 12'h000};
    vecs[17] = '{1'b0, AW'(3), 12'h000};
    vecs[18] = '{1'b1, AW'(19), 12'h000};
    vecs[19] = '{1'b1, {AW{1'b1}}, 12'h000};

    // Reset state and the power-on clear.
    @(negedge clk);
    checkOutput("rst_data", 32'(sprite_data), 32'h000);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_ready", 32'(load_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", 32'(load_count), 32'd0);
    resetN = 1'b1;
    check_clear_sequence("t1_clr");
    read_cycle(1'b1, AW'(7), 12'h000);
    drain();

    // Full load, then back-to-back reads including out-of-range and no-read.
    full_load(12'h100, "t2_load");
    for (int v = 0; v < 20; v++) read_cycle(vecs[v].rd, vecs[v].addr, vecs[v].exp_pix);
    drain();

    // Gappy load ending on load_last, with reads issued during the load.
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, '0, 1'b0, 12'h000);
    for (int j = 0; j < 7; j++) begin
      if (j % 2 == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b1, (j == 6) ? 12'hABC : pixel_t'(12'hA01 + 12'(j / 2)),
                      (j == 6), 1'b0, '0, 1'b0, 12'h000);
        model_mem[j / 2] = (j == 6) ? 12'hABC : pixel_t'(12'hA01 + 12'(j / 2));
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 12'hEEE, 1'b0, 1'b1, AW'(3), 1'b1, 12'h000);
      end
    end
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_ready", 32'(load_ready), 32'd0);
    checkOutput("t4_count", 32'(load_count), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, '0, 1'b0, 12'h000);
    checkOutput("t4_drop_done", 32'(done), 32'd0);
    checkOutput("t4_drop_count", 32'(load_count), 32'd4);
    for (int a = 0; a < 5; a++) read_cycle(1'b1, AW'(a), model_mem[a]);
    drain();
    checkOutput("t4_addr4_model", 32'(model_mem[4]), 32'h104);

    // Simultaneous starts: clear wins, later starts during CLEAR are ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, '0, 1'b0, 12'h000);
    n_done  = int'(done);
    n_busy  = int'(busy);
    n_ready = int'(load_ready);
    for (int k = 0; k < 24; k++) begin
      applyStimulus((k == 5), (k == 3), 1'b0, 12'h000, 1'b0, 1'b0, '0, 1'b0, 12'h000);
      n_done  += int'(done);
      n_busy  += int'(busy);
      n_ready += int'(load_ready);
    end
    checkOutput("t5_done_pulses", 32'(n_done), 32'd1);
    checkOutput("t5_busy_cycles", 32'(n_busy), 32'(DEPTH));
    checkOutput("t5_ready_cycles", 32'(n_ready), 32'd0);
    checkOutput("t5_count_kept", 32'(load_count), 32'd4);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 12'h000;
    for (int a = 0; a < 5; a++) read_cycle(1'b1, AW'(a), model_mem[a]);
    drain();

    // Reset in the middle of a load aborts it and restarts the clear.
    full_load(12'h300, "t6_pre");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, '0, 1'b0, 12'h000);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, pixel_t'(12'h200 + 12'(i)), 1'b0, 1'b0, '0, 1'b0, 12'h000);
    checkOutput("t6_count_pre", 32'(load_count), 32'd7);
    load_valid = 1'b1;
    load_data  = 12'h207;
    #2 resetN = 1'b0;
    #1;
    checkOutput("t6_async_data", 32'(sprite_data), 32'h000);
    checkOutput("t6_async_ready", 32'(load_ready), 32'd0);
    checkOutput("t6_async_busy", 32'(busy), 32'd1);
    checkOutput("t6_async_count", 32'(load_count), 32'd0);
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    check_clear_sequence("t6_clr");
    for (int a = 0; a < DEPTH; a++) read_cycle(1'b1, AW'(a), model_mem[a]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
